// File: rtl/noc_input_port_pkg.sv
// Shared flit format, port indices and XY routing helper for the NoC router input stage.
package noc_input_port_pkg;

  localparam int COORD_W   = 4;
  localparam int PAYLOAD_W = 16;
  localparam int NUM_PORTS = 5;

  localparam int EAST  = 0;
  localparam int WEST  = 1;
  localparam int SOUTH = 2;
  localparam int NORTH = 3;
  localparam int LOCAL = 4;

  typedef enum logic [1:0] {
    HEAD   = 2'b00,
    BODY   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  typedef struct packed {
    flit_type_e           ftype;
    logic [COORD_W-1:0]   dst_x;
    logic [COORD_W-1:0]   dst_y;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  localparam int FLIT_W = $bits(flit_t);

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } port_state_e;

  // Dimension-ordered routing: resolve X fully before Y.
  function automatic logic [NUM_PORTS-1:0] xy_route(
    input logic [COORD_W-1:0] dst_x,
    input logic [COORD_W-1:0] dst_y,
    input logic [COORD_W-1:0] cur_x,
    input logic [COORD_W-1:0] cur_y
  );
    logic [NUM_PORTS-1:0] req;
    req = '0;
    if (dst_x > cur_x)      req[EAST]  = 1'b1;
    else if (dst_x < cur_x) req[WEST]  = 1'b1;
    else if (dst_y > cur_y) req[NORTH] = 1'b1;
    else if (dst_y < cur_y) req[SOUTH] = 1'b1;
    else                    req[LOCAL] = 1'b1;
    return req;
  endfunction

endpackage

// File: rtl/noc_input_port_flit_fifo.sv
// Flit buffer: push visible at the front the next cycle, combinational read from storage.
// Push is ignored when full and pop is ignored when empty.
module noc_flit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en, pop_en;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_dat  = mem_q[rd_ptr_q];
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // Pointers are exactly log2(DEPTH) wide, so they wrap without compare logic.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_en);
    count_d  = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wr_dat;
  end

endmodule

// File: rtl/noc_input_port.sv
// Router input stage: buffers flits, routes each head XY-style and holds the one-hot request for the packet.
// Head reaches the output two cycles after push; in_ready is just !full, with no path from out_ready.
module noc_input_port
  import noc_input_port_pkg::*;
#(
  parameter int                 DEPTH = 4,
  parameter logic [COORD_W-1:0] CUR_X = '0,
  parameter logic [COORD_W-1:0] CUR_Y = '0
) (
  input  logic                 noc_clk,
  input  logic                 noc_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FLIT_W-1:0]    in_flit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FLIT_W-1:0]    out_flit,
  output logic [NUM_PORTS-1:0] out_port,
  output logic                 err_drop
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [FLIT_W-1:0]    fifo_rd_dat;
  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  flit_t                front;
  logic                 push, pop, drop, take;
  logic                 front_is_head, front_is_last;

  port_state_e          state_q, state_d;
  logic [NUM_PORTS-1:0] out_port_q, out_port_d;
  logic                 err_drop_q, err_drop_d;

  noc_flit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FLIT_W)
  ) u_fifo (
    .clk    (noc_clk),
    .rst_n  (noc_rst_n),
    .push   (push),
    .wr_dat (in_flit),
    .pop    (pop),
    .rd_dat (fifo_rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign front         = flit_t'(fifo_rd_dat);
  assign front_is_head = (front.ftype == HEAD) || (front.ftype == SINGLE);
  assign front_is_last = (front.ftype == TAIL) || (front.ftype == SINGLE);

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign out_valid = (state_q == ST_ACTIVE) && !fifo_empty;
  assign take      = out_valid && out_ready;
  // A stray body/tail at the front of an idle port is discarded so it cannot block the lane.
  assign drop      = (state_q == ST_IDLE) && !fifo_empty && !front_is_head;
  assign pop       = take || drop;

  assign out_flit  = fifo_rd_dat;
  assign out_port  = out_port_q;
  assign err_drop  = err_drop_q;

  always_comb begin
    state_d    = state_q;
    out_port_d = out_port_q;
    err_drop_d = err_drop_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (front_is_head) begin
            out_port_d = xy_route(front.dst_x, front.dst_y, CUR_X, CUR_Y);
            state_d    = ST_ACTIVE;
          end else begin
            err_drop_d = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (take && front_is_last) begin
          out_port_d = '0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q    <= ST_IDLE;
      out_port_q <= '0;
      err_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_port_q <= out_port_d;
      err_drop_q <= err_drop_d;
    end
  end

  assert property (@(posedge noc_clk) disable iff (!noc_rst_n) fifo_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_noc_input_port.sv
// Directed bench for noc_input_port at router (1,1): queue-based packet model plus literal timing checks.
module tb_noc_input_port;
  import noc_input_port_pkg::*;

  localparam int DEPTH = 4;
  localparam int CX    = 1;
  localparam int CY    = 1;

  logic                 noc_clk;
  logic                 noc_rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [FLIT_W-1:0]    in_flit;
  logic                 out_valid;
  logic                 out_ready;
  logic [FLIT_W-1:0]    out_flit;
  logic [NUM_PORTS-1:0] out_port;
  logic                 err_drop;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_out  = 0;

  typedef struct {
    logic [FLIT_W-1:0]    f;
    logic [NUM_PORTS-1:0] p;
  } exp_t;

  exp_t                 exp_q[$];
  logic                 m_open;
  logic [NUM_PORTS-1:0] m_port;

  flit_t                stim_q[$];
  logic                 sv [16];
  logic [NUM_PORTS-1:0] sp [16];
  logic                 se [16];
  logic                 s_valid, s_in_ready, s_err;
  logic [NUM_PORTS-1:0] s_port;

  noc_input_port #(
    .DEPTH (DEPTH),
    .CUR_X (4'd1),
    .CUR_Y (4'd1)
  ) dut (
    .noc_clk   (noc_clk),
    .noc_rst_n (noc_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_flit   (in_flit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_flit  (out_flit),
    .out_port  (out_port),
    .err_drop  (err_drop)
  );

  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_PORTS-1:0] model_route(input int dx, input int dy);
    int dir;
    if (dx > CX)      dir = EAST;
    else if (dx < CX) dir = WEST;
    else if (dy > CY) dir = NORTH;
    else if (dy < CY) dir = SOUTH;
    else              dir = LOCAL;
    return NUM_PORTS'(1 << dir);
  endfunction

  function automatic flit_t mk(input flit_type_e t, input int x, input int y, input int pl);
    flit_t f;
    f.ftype   = t;
    f.dst_x   = COORD_W'(x);
    f.dst_y   = COORD_W'(y);
    f.payload = PAYLOAD_W'(pl);
    return f;
  endfunction

  // Packet-level model: what must leave, in order, and on which port.
  task automatic model_push(input logic [FLIT_W-1:0] raw);
    flit_t fl;
    exp_t  e;
    fl = flit_t'(raw);
    if (fl.ftype == HEAD || fl.ftype == SINGLE) begin
      m_port = model_route(int'(fl.dst_x), int'(fl.dst_y));
      m_open = (fl.ftype == HEAD);
      e.f = raw; e.p = m_port;
      exp_q.push_back(e);
    end else if (m_open) begin
      e.f = raw; e.p = m_port;
      exp_q.push_back(e);
      if (fl.ftype == TAIL) m_open = 1'b0;
    end
  endtask

  always @(negedge noc_clk) begin
    if (!noc_rst_n) begin
      exp_q.delete();
      m_open = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          chk("out_flit", 32'(out_flit), 32'(exp_q[0].f));
          chk("out_port", 32'(out_port), 32'(exp_q[0].p));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) model_push(in_flit);
    end
  end

  task automatic step(input logic vld, input flit_t fl, input logic rdy);
    in_valid  = vld;
    in_flit   = fl;
    out_ready = rdy;
    @(negedge noc_clk);
    s_valid    = out_valid;
    s_port     = out_port;
    s_in_ready = in_ready;
    s_err      = err_drop;
    @(posedge noc_clk);
    #1;
  endtask

  // Offers stim_q back-to-back; sample i is taken in the cycle before edge i.
  task automatic seq(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      if (i < stim_q.size()) step(1'b1, stim_q[i], rdy);
      else                   step(1'b0, '0, rdy);
      sv[i] = s_valid;
      sp[i] = s_port;
      se[i] = s_err;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int k;
    int n0;
    flit_t big [6];

    in_valid  = 1'b0;
    in_flit   = '0;
    out_ready = 1'b0;
    m_open    = 1'b0;
    m_port    = '0;
    noc_rst_n = 1'b1;
    #1 noc_rst_n = 1'b0;
    #2;
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_port",  32'(out_port),      32'd0);
    chk("rst_err_drop",  {31'b0, err_drop},  32'd0);
    @(posedge noc_clk);
    @(posedge noc_clk);
    #1 noc_rst_n = 1'b1;

    chk("model_route_local", 32'(model_route(1, 1)), 32'h10);
    chk("model_route_north", 32'(model_route(1, 2)), 32'h08);

    // Single flit east.
    stim_q = {mk(SINGLE, 2, 1, 'h0011)};
    seq(4, 1'b1);
    chk("single_c1_valid", {31'b0, sv[1]}, 32'd0);
    chk("single_c2_valid", {31'b0, sv[2]}, 32'd1);
    chk("single_c2_port",  32'(sp[2]),     32'h01);
    chk("single_c3_port",  32'(sp[3]),     32'h00);

    // Four-flit packet south at full rate.
    stim_q = {mk(HEAD, 1, 0, 'h0101), mk(BODY, 1, 0, 'h0102),
              mk(BODY, 1, 0, 'h0103), mk(TAIL, 1, 0, 'h0104)};
    seq(8, 1'b1);
    chk("pkt_c1_valid", {31'b0, sv[1]}, 32'd0);
    for (int i = 2; i <= 5; i++) begin
      chk("pkt_valid", {31'b0, sv[i]}, 32'd1);
      chk("pkt_port",  32'(sp[i]),     32'h04);
    end
    chk("pkt_c6_valid", {31'b0, sv[6]}, 32'd0);
    chk("pkt_c6_port",  32'(sp[6]),     32'h00);

    // Six flits offered into a 4-deep buffer with the crossbar stalled.
    big[0] = mk(HEAD, 0, 1, 'h0201);
    for (int i = 1; i < 5; i++) big[i] = mk(BODY, 0, 1, 'h0201 + i);
    big[5] = mk(TAIL, 0, 1, 'h0206);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, big[k], 1'b0);
      if (s_in_ready) k++;
    end
    chk("stall_accepted",     32'(k),               32'd4);
    chk("stall_full_ready",   {31'b0, s_in_ready},  32'd0);
    chk("stall_holds_valid",  {31'b0, s_valid},     32'd1);
    n0 = n_out;
    for (int i = 0; i < 40 && (n_out - n0) < 6; i++) begin
      if (k < 6) begin
        step(1'b1, big[k], 1'b1);
        if (s_in_ready) k++;
      end else begin
        step(1'b0, '0, 1'b1);
      end
    end
    in_valid = 1'b0;
    chk("stall_all_exited", 32'(n_out - n0), 32'd6);

    // Orphan body flit is dropped, then a head routes north.
    stim_q = {mk(BODY, 2, 1, 'h0301)};
    seq(4, 1'b1);
    chk("drop_no_valid", {31'b0, (sv[1] | sv[2] | sv[3])}, 32'd0);
    chk("drop_err_set",  {31'b0, se[3]},                   32'd1);
    stim_q = {mk(HEAD, 1, 2, 'h0302), mk(TAIL, 1, 2, 'h0303)};
    seq(5, 1'b1);
    chk("after_drop_valid", {31'b0, sv[2]}, 32'd1);
    chk("after_drop_port",  32'(sp[2]),     32'h08);
    chk("err_sticky",       {31'b0, se[4]}, 32'd1);

    // Back-to-back singles: local, bubble, west.
    stim_q = {mk(SINGLE, 1, 1, 'h0401), mk(SINGLE, 0, 1, 'h0402)};
    seq(6, 1'b1);
    chk("b2b_c2_port",  32'(sp[2]),     32'h10);
    chk("b2b_c3_valid", {31'b0, sv[3]}, 32'd0);
    chk("b2b_c3_port",  32'(sp[3]),     32'h00);
    chk("b2b_c4_port",  32'(sp[4]),     32'h02);
    chk("b2b_c5_port",  32'(sp[5]),     32'h00);

    // Reset with three flits of an open packet buffered.
    stim_q = {mk(HEAD, 2, 1, 'h0501), mk(BODY, 2, 1, 'h0502), mk(BODY, 2, 1, 'h0503)};
    seq(3, 1'b0);
    noc_rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("midrst_err_drop",  {31'b0, err_drop},  32'd0);
    chk("midrst_out_port",  32'(out_port),      32'd0);
    @(posedge noc_clk);
    #1 noc_rst_n = 1'b1;
    stim_q = {mk(HEAD, 1, 0, 'h0601), mk(TAIL, 1, 0, 'h0602)};
    seq(5, 1'b1);
    chk("postrst_c1_valid", {31'b0, sv[1]}, 32'd0);
    chk("postrst_c2_valid", {31'b0, sv[2]}, 32'd1);
    chk("postrst_c2_port",  32'(sp[2]),     32'h04);
    chk("postrst_no_err",   {31'b0, se[4]}, 32'd0);

    chk("model_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
